mem_cmd_splitter: RTL

Parametrised successor to the single-shot memory-command path: accepts arbitrary-length memory commands (64-bit address, 32-bit length) and splits them into sub-commands that never exceed MAX_BURST_BYTES and never cross a BOUNDARY_BYTES address boundary. It tracks outstanding parent commands and merges the per-sub-command statuses returned by the data mover into one status per parent. It sits between the DMA/TCP command generators and the memory data mover.

---
 rtl/mem_cmd_splitter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_cmd_splitter.sv
// mem_cmd_splitter: splits arbitrary-length memory commands into sub-commands
// that never exceed MAX_BURST_BYTES and never cross a BOUNDARY_BYTES boundary.
// Tracks split parents in a small count FIFO and merges per-sub statuses
// into one status per parent (error OR, sub count saturated at 127).
module mem_cmd_splitter #(
  parameter int ADDR_WIDTH      = 64,
  parameter int LEN_WIDTH       = 32,
  parameter int MAX_BURST_BYTES = 4096,
  parameter int BOUNDARY_BYTES  = 4096,
  parameter int TRACK_DEPTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_cmd_valid,
  output logic                  s_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] s_cmd_address,
  input  logic [LEN_WIDTH-1:0]  s_cmd_length,
  output logic                  m_cmd_valid,
  input  logic                  m_cmd_ready,
  output logic [ADDR_WIDTH-1:0] m_cmd_address,
  output logic [LEN_WIDTH-1:0]  m_cmd_length,
  input  logic                  s_sts_valid,
  output logic                  s_sts_ready,
  input  logic [7:0]            s_sts_data,
  output logic                  m_sts_valid,
  input  logic                  m_sts_ready,
  output logic [7:0]            m_sts_data,
  output logic                  busy
);

  // Length arithmetic is one bit wider than LEN_WIDTH so that a full
  // boundary window (BOUNDARY_BYTES) never wraps during comparison.
  localparam int CW = LEN_WIDTH + 1;
  localparam int PW = (TRACK_DEPTH > 1) ? $clog2(TRACK_DEPTH) : 1;
  localparam int OW = PW + 2;

  typedef enum logic [0:0] {IDLE, SPLIT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [LEN_WIDTH-1:0]  sub_cnt_q, sub_cnt_d;
  logic                  m_cmd_valid_q, m_cmd_valid_d;
  logic [LEN_WIDTH-1:0]  m_cmd_length_q, m_cmd_length_d;
  logic                  s_cmd_ready_q, s_cmd_ready_d;
  logic                  push_q, push_d;
  logic [LEN_WIDTH-1:0]  push_cnt_q, push_cnt_d;

  logic [LEN_WIDTH-1:0]  fifo_mem [2**PW];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic [LEN_WIDTH-1:0]  done_cnt_q, done_cnt_d;
  logic                  err_acc_q, err_acc_d;
  logic                  m_sts_valid_q, m_sts_valid_d;
  logic [7:0]            m_sts_data_q, m_sts_data_d;
  logic                  run_q, run_d;

  logic                  fifo_empty;
  logic [LEN_WIDTH-1:0]  head_cnt;
  logic                  complete;
  logic                  pop;
  logic                  sts_hs;
  logic [OW-1:0]         occ_d;
  logic                  unused_sts_bits;

  // Sub-command length: min(remaining, max burst, bytes left in the window).
  function automatic logic [LEN_WIDTH-1:0] sub_len(input logic [ADDR_WIDTH-1:0] a,
                                                   input logic [LEN_WIDTH-1:0]  r);
    logic [CW-1:0] room;
    logic [CW-1:0] l;
    room = CW'(BOUNDARY_BYTES) - CW'(a & ADDR_WIDTH'(BOUNDARY_BYTES - 1));
    l    = {1'b0, r};
    if (CW'(MAX_BURST_BYTES) < l) l = CW'(MAX_BURST_BYTES);
    if (room < l) l = room;
    return l[LEN_WIDTH-1:0];
  endfunction

  assign unused_sts_bits = ^s_sts_data[6:0];

  assign s_cmd_ready   = s_cmd_ready_q;
  assign m_cmd_valid   = m_cmd_valid_q;
  assign m_cmd_address = cur_addr_q;
  assign m_cmd_length  = m_cmd_length_q;
  assign m_sts_valid   = m_sts_valid_q;
  assign m_sts_data    = m_sts_data_q;

  // Splitter FSM: accept a parent, then emit one registered sub-command per handshake.
  always_comb begin
    state_d        = state_q;
    cur_addr_d     = cur_addr_q;
    rem_d          = rem_q;
    sub_cnt_d      = sub_cnt_q;
    m_cmd_valid_d  = m_cmd_valid_q;
    m_cmd_length_d = m_cmd_length_q;
    push_d         = 1'b0;
    push_cnt_d     = push_cnt_q;
    case (state_q)
      IDLE: begin
        if (s_cmd_valid && s_cmd_ready_q) begin
          cur_addr_d = s_cmd_address;
          rem_d      = s_cmd_length;
          sub_cnt_d  = '0;
          if (s_cmd_length != '0) begin
            state_d        = SPLIT;
            m_cmd_valid_d  = 1'b1;
            m_cmd_length_d = sub_len(s_cmd_address, s_cmd_length);
          end else begin
            // Zero-length parent still gets a status, with a count of 0.
            push_d     = 1'b1;
            push_cnt_d = '0;
          end
        end
      end
      SPLIT: begin
        if (m_cmd_ready) begin
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(m_cmd_length_q);
          rem_d      = rem_q - m_cmd_length_q;
          sub_cnt_d  = sub_cnt_q + LEN_WIDTH'(1);
          if (rem_d == '0) begin
            state_d       = IDLE;
            m_cmd_valid_d = 1'b0;
            push_d        = 1'b1;
            push_cnt_d    = sub_cnt_d;
          end else begin
            m_cmd_length_d = sub_len(cur_addr_d, rem_d);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status collector: count sub-statuses, merge errors, retire the FIFO head when complete.
  always_comb begin
    fifo_empty    = (count_q == '0);
    head_cnt      = fifo_mem[rd_ptr_q];
    complete      = !fifo_empty && (done_cnt_q == head_cnt);
    pop           = complete && !m_sts_valid_q;
    s_sts_ready   = run_q && !m_sts_valid_q && !complete;
    sts_hs        = s_sts_valid && s_sts_ready;
    wr_ptr_d      = wr_ptr_q + PW'(push_q);
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    count_d       = count_q + (PW+1)'(push_q) - (PW+1)'(pop);
    done_cnt_d    = done_cnt_q;
    err_acc_d     = err_acc_q;
    m_sts_valid_d = m_sts_valid_q;
    m_sts_data_d  = m_sts_data_q;
    run_d         = 1'b1;
    if (pop) begin
      m_sts_valid_d = 1'b1;
      m_sts_data_d  = {err_acc_q, (head_cnt > LEN_WIDTH'(127)) ? 7'd127 : head_cnt[6:0]};
      done_cnt_d    = '0;
      err_acc_d     = 1'b0;
    end else begin
      if (m_sts_valid_q && m_sts_ready) m_sts_valid_d = 1'b0;
      if (sts_hs) begin
        done_cnt_d = done_cnt_q + LEN_WIDTH'(1);
        err_acc_d  = err_acc_q | s_sts_data[7];
      end
    end
  end

  // Parent ready for the next cycle; pending pushes count as occupied slots.
  always_comb begin
    occ_d         = OW'(count_d) + OW'(push_d);
    s_cmd_ready_d = (state_d == IDLE) && (occ_d < OW'(TRACK_DEPTH));
  end

  // busy also covers the one cycle between the last sub and its FIFO push.
  assign busy = (state_q == SPLIT) || push_q || !fifo_empty ||
                (done_cnt_q != '0) || m_sts_valid_q;

  // State registers; reset drops every pre-reset parent and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cur_addr_q     <= '0;
      rem_q          <= '0;
      sub_cnt_q      <= '0;
      m_cmd_valid_q  <= 1'b0;
      m_cmd_length_q <= '0;
      s_cmd_ready_q  <= 1'b0;
      push_q         <= 1'b0;
      push_cnt_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      done_cnt_q     <= '0;
      err_acc_q      <= 1'b0;
      m_sts_valid_q  <= 1'b0;
      m_sts_data_q   <= '0;
      run_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_addr_q     <= cur_addr_d;
      rem_q          <= rem_d;
      sub_cnt_q      <= sub_cnt_d;
      m_cmd_valid_q  <= m_cmd_valid_d;
      m_cmd_length_q <= m_cmd_length_d;
      s_cmd_ready_q  <= s_cmd_ready_d;
      push_q         <= push_d;
      push_cnt_q     <= push_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      done_cnt_q     <= done_cnt_d;
      err_acc_q      <= err_acc_d;
      m_sts_valid_q  <= m_sts_valid_d;
      m_sts_data_q   <= m_sts_data_d;
      run_q          <= run_d;
    end
  end

  // Tracking FIFO storage; validity is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_q) fifo_mem[wr_ptr_q] <= push_cnt_q;
  end

endmodule
